// File: rtl/program_memory_bist_master_if.sv
// Avalon-MM bus between the BIST master and the program memory slave port.
`timescale 1ns/1ps
interface program_memory_bist_master_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] m_address;
    logic [BE_WIDTH-1:0]   m_byteenable;
    logic                  m_chipselect;
    logic                  m_write;
    logic [DATA_WIDTH-1:0] m_writedata;
    logic                  m_clken;
    logic [DATA_WIDTH-1:0] m_readdata;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata
    );
endinterface

// File: rtl/program_memory_bist_master.sv
// Program memory BIST: fills words 0..len-1 with a seeded pattern, optionally reads back and compares.
`timescale 1ns/1ps
module program_memory_bist_master #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WORDS  = 40960,
    parameter int unsigned ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  verify,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [15:0]           word_count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] first_error_addr,
    program_memory_bist_master_if.master mem
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned LEN_WIDTH = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] exp_addr, exp_addr_nxt;
    logic                  exp_valid, exp_valid_nxt;
    logic [LEN_WIDTH-1:0]  len, len_nxt, len_start;
    logic [DATA_WIDTH-1:0] seed_q, seed_nxt;
    logic                  verify_q, verify_nxt;
    logic                  busy_nxt, done_nxt, pass_nxt;
    logic [ERR_WIDTH-1:0]  err_nxt;
    logic [ADDR_WIDTH-1:0] first_nxt;
    logic                  cs_nxt, wr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  last_addr;
    logic                  mismatch;

    // P(a) = {a[15:0], ~a[15:0]} ^ seed
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] s);
        logic [15:0] a16;
        a16 = 16'(a);
        return DATA_WIDTH'({a16, ~a16}) ^ s;
    endfunction

    assign mem.m_clken = 1'b1;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            exp_addr           <= '0;
            exp_valid          <= 1'b0;
            len                <= '0;
            seed_q             <= '0;
            verify_q           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            error_count        <= '0;
            first_error_addr   <= '0;
            mem.m_address      <= '0;
            mem.m_byteenable   <= '0;
            mem.m_chipselect   <= 1'b0;
            mem.m_write        <= 1'b0;
            mem.m_writedata    <= '0;
        end else begin
            state              <= state_nxt;
            exp_addr           <= exp_addr_nxt;
            exp_valid          <= exp_valid_nxt;
            len                <= len_nxt;
            seed_q             <= seed_nxt;
            verify_q           <= verify_nxt;
            busy               <= busy_nxt;
            done               <= done_nxt;
            pass               <= pass_nxt;
            error_count        <= err_nxt;
            first_error_addr   <= first_nxt;
            mem.m_address      <= addr_nxt;
            mem.m_byteenable   <= cs_nxt ? {BE_WIDTH{1'b1}} : {BE_WIDTH{1'b0}};
            mem.m_chipselect   <= cs_nxt;
            mem.m_write        <= wr_nxt;
            mem.m_writedata    <= wdata_nxt;
        end
    end

    // Next-state, access sequencing and read-back compare
    always_comb begin
        state_nxt     = state;
        addr_nxt      = mem.m_address;
        exp_addr_nxt  = exp_addr;
        exp_valid_nxt = 1'b0;
        len_nxt       = len;
        seed_nxt      = seed_q;
        verify_nxt    = verify_q;
        done_nxt      = 1'b0;
        pass_nxt      = pass;
        err_nxt       = error_count;
        first_nxt     = first_error_addr;
        cs_nxt        = 1'b0;
        wr_nxt        = 1'b0;
        wdata_nxt     = '0;
        len_start     = (32'(word_count) > MAX_WORDS) ? LEN_WIDTH'(MAX_WORDS)
                                                      : LEN_WIDTH'(word_count);
        last_addr     = (32'(mem.m_address) + 32'd1) == 32'(len);
        mismatch      = exp_valid && (mem.m_readdata != pattern(exp_addr, seed_q));

        // Compare the word returned for the read issued last cycle
        if (mismatch) begin
            if (error_count != {ERR_WIDTH{1'b1}}) begin
                err_nxt = error_count + ERR_WIDTH'(1);
            end
            if (error_count == '0) begin
                first_nxt = exp_addr;
            end
        end

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    seed_nxt   = seed;
                    verify_nxt = verify;
                    len_nxt    = len_start;
                    err_nxt    = '0;
                    first_nxt  = '0;
                    pass_nxt   = 1'b0;
                    addr_nxt   = '0;
                    if (len_start == '0) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_WRITE;
                        cs_nxt    = 1'b1;
                        wr_nxt    = 1'b1;
                        wdata_nxt = pattern('0, seed);
                    end
                end
            end
            ST_WRITE: begin
                if (last_addr) begin
                    addr_nxt = '0;
                    if (verify_q) begin
                        state_nxt = ST_READ;
                        cs_nxt    = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b1;
                    end
                end else begin
                    addr_nxt  = mem.m_address + ADDR_WIDTH'(1);
                    cs_nxt    = 1'b1;
                    wr_nxt    = 1'b1;
                    wdata_nxt = pattern(addr_nxt, seed_q);
                end
            end
            ST_READ: begin
                exp_valid_nxt = 1'b1;
                exp_addr_nxt  = mem.m_address;
                if (last_addr) begin
                    state_nxt = ST_DRAIN;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = mem.m_address + ADDR_WIDTH'(1);
                    cs_nxt   = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
                pass_nxt  = (err_nxt == '0);
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort beats start and drops any in-flight compare
        if (abort && (state == ST_WRITE || state == ST_READ || state == ST_DRAIN)) begin
            state_nxt     = ST_DONE;
            done_nxt      = 1'b1;
            pass_nxt      = 1'b0;
            cs_nxt        = 1'b0;
            wr_nxt        = 1'b0;
            wdata_nxt     = '0;
            addr_nxt      = '0;
            exp_valid_nxt = 1'b0;
            err_nxt       = error_count;
            first_nxt     = first_error_addr;
        end

        busy_nxt = (state_nxt == ST_WRITE) || (state_nxt == ST_READ) || (state_nxt == ST_DRAIN);
    end
endmodule
